psola_readout: RTL and testbench

PSOLA_READOUT -- requirements
Module: psola_readout

---
 rtl/psola_readout.sv | 194 +++++++++++++++++++
 tb/tb_psola_readout.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psola_readout.sv
// psola_readout: streams a synthesized PSOLA window out of the overlap-add
// buffer one audio sample per sample_tick. Each buffer word is fetched
// through a 2-cycle read pipeline and converted to OUT_WIDTH bits.
// The word is arithmetically shifted right by FRAC_BITS and then saturated.
// Optional feature macro: PSOLA_READOUT_CLEAR_EN. When it is defined, each
// emitted buffer word is zeroed so the next overlap-add starts from clean
// storage.
module psola_readout #(
    parameter int WINDOW_SIZE = 2048,
    parameter int FRAC_BITS   = 10,
    parameter int OUT_WIDTH   = 16,
    localparam int LOG_WINDOW_SIZE = $clog2(WINDOW_SIZE)
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         start,
    input  logic [LOG_WINDOW_SIZE:0]     window_len,
    input  logic                         sample_tick,
    output logic [LOG_WINDOW_SIZE:0]     read_addr,
    input  logic [31:0]                  read_data,
    output logic [LOG_WINDOW_SIZE:0]     clear_addr,
    output logic                         clear_en,
    output logic signed [OUT_WIDTH-1:0]  sample_out,
    output logic                         sample_valid,
    output logic                         busy,
    output logic                         done,
    output logic                         underrun
);

    localparam int AW = LOG_WINDOW_SIZE + 1;
    localparam logic [AW-1:0] IDX_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] LEN_MAX  = AW'(WINDOW_SIZE);
    localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (OUT_WIDTH - 1)) - 32'sd1;
    localparam logic signed [31:0] SAT_MIN = -(32'sd1 <<< (OUT_WIDTH - 1));

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT1  = 3'd2,
        WAIT2  = 3'd3,
        READY  = 3'd4,
        FINISH = 3'd5
    } state_t;

    // Fixed-point buffer word to saturated audio sample (floor division by 2^FRAC_BITS).
    function automatic logic [OUT_WIDTH-1:0] convert(input logic [31:0] word);
        logic signed [31:0]   shifted;
        logic [OUT_WIDTH-1:0] result;
        shifted = $signed(word) >>> FRAC_BITS;
        if (shifted > SAT_MAX) begin
            result = SAT_MAX[OUT_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            result = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            result = shifted[OUT_WIDTH-1:0];
        end
        return result;
    endfunction

    state_t               state_r, next_state_s;
    logic [AW-1:0]        idx_r, idx_s, idx_inc_s;
    logic [AW-1:0]        len_r, len_s, len_clamped_s;
    logic [OUT_WIDTH-1:0] hold_r, hold_s;
    logic [OUT_WIDTH-1:0] out_s;
    logic [AW-1:0]        read_addr_s;
    logic                 valid_s, busy_s, done_s, underrun_s;

    assign idx_inc_s     = idx_r + IDX_ONE;
    assign len_clamped_s = (window_len > LEN_MAX) ? LEN_MAX : window_len;

    // State register; reset returns to IDLE from anywhere, even mid-window.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a start pulse takes priority over everything else.
    always_comb begin
        next_state_s = state_r;
        if (start) begin
            next_state_s = (window_len == IDX_ZERO) ? FINISH : ISSUE;
        end else begin
            case (state_r)
                IDLE:   next_state_s = IDLE;
                ISSUE:  next_state_s = WAIT1;
                WAIT1:  next_state_s = WAIT2;
                WAIT2:  next_state_s = READY;
                READY: begin
                    if (sample_tick) begin
                        next_state_s = (idx_inc_s < len_r) ? ISSUE : FINISH;
                    end else begin
                        next_state_s = READY;
                    end
                end
                FINISH: next_state_s = IDLE;
                default: next_state_s = IDLE;
            endcase
        end
    end

    // Output/datapath next values; every output is registered below.
    always_comb begin
        idx_s       = idx_r;
        len_s       = len_r;
        hold_s      = hold_r;
        out_s       = sample_out;
        read_addr_s = read_addr;
        valid_s     = 1'b0;
        busy_s      = busy;
        done_s      = 1'b0;
        underrun_s  = 1'b0;
        if (start) begin
            idx_s       = IDX_ZERO;
            read_addr_s = IDX_ZERO;
            if (window_len == IDX_ZERO) begin
                busy_s = 1'b0;
                done_s = 1'b1;
            end else begin
                len_s  = len_clamped_s;
                busy_s = 1'b1;
            end
        end else begin
            case (state_r)
                ISSUE, WAIT1: underrun_s = sample_tick;
                WAIT2: begin
                    underrun_s = sample_tick;
                    hold_s     = convert(read_data);
                end
                READY: begin
                    if (sample_tick) begin
                        valid_s = 1'b1;
                        out_s   = hold_r;
                        idx_s   = idx_inc_s;
                        if (idx_inc_s < len_r) begin
                            read_addr_s = idx_inc_s;
                        end else begin
                            busy_s = 1'b0;
                            done_s = 1'b1;
                        end
                    end else begin
                        valid_s = 1'b0;
                    end
                end
                default: underrun_s = 1'b0;
            endcase
        end
    end

    // Registered datapath and outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            idx_r        <= IDX_ZERO;
            len_r        <= IDX_ZERO;
            hold_r       <= {OUT_WIDTH{1'b0}};
            sample_out   <= {OUT_WIDTH{1'b0}};
            read_addr    <= IDX_ZERO;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            idx_r        <= idx_s;
            len_r        <= len_s;
            hold_r       <= hold_s;
            sample_out   <= out_s;
            read_addr    <= read_addr_s;
            sample_valid <= valid_s;
            busy         <= busy_s;
            done         <= done_s;
            underrun     <= underrun_s;
        end
    end

`ifdef PSOLA_READOUT_CLEAR_EN
    // Zero the word just emitted, aligned with its sample_valid pulse.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            clear_en   <= 1'b0;
            clear_addr <= IDX_ZERO;
        end else begin
            clear_en   <= valid_s;
            clear_addr <= valid_s ? idx_r : clear_addr;
        end
    end
`else
    assign clear_en   = 1'b0;
    assign clear_addr = IDX_ZERO;
`endif

endmodule

// File: tb/tb_psola_readout.sv
// Self-checking bench for psola_readout (default parameters). Buffer words
// come from a behavioural memory with a 2-cycle read latency. Expected
// samples come from floor division plus clamping on plain integers.
module tb_psola_readout;

    localparam int WS   = 2048;
    localparam int FRAC = 10;
    localparam int AW   = 12;

    logic                 clk_in = 1'b0;
    logic                 rst_in = 1'b1;
    logic                 start = 1'b0;
    logic [AW-1:0]        window_len = '0;
    logic                 sample_tick = 1'b0;
    logic [AW-1:0]        read_addr;
    logic [31:0]          read_data;
    logic [AW-1:0]        clear_addr;
    logic                 clear_en;
    logic signed [15:0]   sample_out;
    logic                 sample_valid, busy, done, underrun;

    int errors = 0;
    int checks = 0;

    logic [31:0]   mem [0:4095];
    logic [AW-1:0] pipe1 = '0, pipe2 = '0;

    psola_readout dut (
        .clk_in(clk_in), .rst_in(rst_in), .start(start), .window_len(window_len),
        .sample_tick(sample_tick), .read_addr(read_addr), .read_data(read_data),
        .clear_addr(clear_addr), .clear_en(clear_en), .sample_out(sample_out),
        .sample_valid(sample_valid), .busy(busy), .done(done), .underrun(underrun)
    );

    always #5 clk_in = ~clk_in;

    // Buffer memory: data for an address appears two cycles after it is driven.
    always @(posedge clk_in) begin
        pipe1 <= read_addr;
        pipe2 <= pipe1;
    end
    assign read_data = mem[pipe2];

    function automatic int expect_sample(input logic [31:0] w);
        longint v, q;
        v = longint'($signed(w));
        q = v / (64'sd1 << FRAC);
        if ((v % (64'sd1 << FRAC)) != 0 && v < 0) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_n(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_start(input int len);
        start = 1'b1;
        window_len = AW'(len);
        step();
        start = 1'b0;
    endtask

    task automatic do_tick();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
    endtask

    // Plays a whole window: start, one tick per sample, then checks the idle tail.
    task automatic run_window(input string name, input int len_req, input int gmin, input int gmax);
        int n, exp_v, last_v;
        n = (len_req > WS) ? WS : len_req;
        last_v = 0;
        do_start(len_req);
        checks++;
        if (busy !== 1'b1 || sample_valid !== 1'b0) begin
            $display("FAIL %s_start: busy=%b valid=%b, required busy=1 valid=0", name, busy, sample_valid);
            errors++;
        end
        for (int i = 0; i < n; i++) begin
            wait_n(int'($urandom_range(gmax, gmin)));
            checks++;
            if (sample_valid !== 1'b0 || done !== 1'b0 || clear_en !== 1'b0) begin
                $display("FAIL %s_quiet[%0d]: valid=%b done=%b clear_en=%b, required 0", name, i, sample_valid, done, clear_en);
                errors++;
            end
            do_tick();
            exp_v = expect_sample(mem[i]);
            last_v = exp_v;
            checks++;
            if (sample_valid !== 1'b1 || int'(sample_out) !== exp_v) begin
                $display("FAIL %s_sample[%0d]: valid=%b out=%0d, required valid=1 out=%0d", name, i, sample_valid, sample_out, exp_v);
                errors++;
            end
`ifdef PSOLA_READOUT_CLEAR_EN
            checks++;
            if (clear_en !== 1'b1 || clear_addr !== AW'(i)) begin
                $display("FAIL %s_clear[%0d]: clear_en=%b addr=%0d, required 1 addr=%0d", name, i, clear_en, clear_addr, i);
                errors++;
            end
`else
            checks++;
            if (clear_en !== 1'b0 || clear_addr !== '0) begin
                $display("FAIL %s_clear[%0d]: clear_en=%b addr=%0d, required 0 addr=0", name, i, clear_en, clear_addr);
                errors++;
            end
`endif
            checks++;
            if (i == n - 1) begin
                if (done !== 1'b1 || busy !== 1'b0) begin
                    $display("FAIL %s_done: done=%b busy=%b, required done=1 busy=0", name, done, busy);
                    errors++;
                end
            end else begin
                if (done !== 1'b0 || busy !== 1'b1) begin
                    $display("FAIL %s_mid[%0d]: done=%b busy=%b, required done=0 busy=1", name, i, done, busy);
                    errors++;
                end
            end
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sample_valid !== 1'b0 || int'(sample_out) !== last_v) begin
            $display("FAIL %s_tail: done=%b busy=%b valid=%b out=%0d, required 0 0 0 out=%0d",
                     name, done, busy, sample_valid, sample_out, last_v);
            errors++;
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        wait_n(3);
        checks++;
        if (sample_out !== 16'sd0 || sample_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL reset_out: out=%0d valid=%b busy=%b done=%b, required all 0", sample_out, sample_valid, busy, done);
            errors++;
        end
        checks++;
        if (underrun !== 1'b0 || clear_en !== 1'b0 || read_addr !== '0 || clear_addr !== '0) begin
            $display("FAIL reset_aux: underrun=%b clear_en=%b read_addr=%0d clear_addr=%0d, required all 0",
                     underrun, clear_en, read_addr, clear_addr);
            errors++;
        end
        rst_in = 1'b0;
        step();
    endtask

    task automatic test_basic();
        mem[0] = 32'h0000_0400;
        mem[1] = 32'hFFFF_FC00;
        mem[2] = 32'h0000_01FF;
        run_window("basic", 3, 9, 9);
    endtask

    task automatic test_saturation();
        mem[0] = 32'h7FFF_FFFF;
        mem[1] = 32'h8000_0000;
        mem[2] = 32'h0001_0000;
        run_window("sat", 3, 3, 6);
    endtask

    task automatic test_underrun();
        int exp_v;
        do_tick();
        checks++;
        if (underrun !== 1'b0 || sample_valid !== 1'b0) begin
            $display("FAIL idle_tick: underrun=%b valid=%b, required 0 0", underrun, sample_valid);
            errors++;
        end
        mem[0] = $urandom;
        exp_v = expect_sample(mem[0]);
        do_start(1);
        do_tick();
        checks++;
        if (underrun !== 1'b1 || sample_valid !== 1'b0) begin
            $display("FAIL underrun_pulse: underrun=%b valid=%b, required 1 0", underrun, sample_valid);
            errors++;
        end
        step();
        checks++;
        if (underrun !== 1'b0) begin
            $display("FAIL underrun_width: underrun=%b, required 0", underrun);
            errors++;
        end
        wait_n(3);
        do_tick();
        checks++;
        if (sample_valid !== 1'b1 || int'(sample_out) !== exp_v || done !== 1'b1 || underrun !== 1'b0) begin
            $display("FAIL underrun_recover: valid=%b out=%0d done=%b underrun=%b, required 1 %0d 1 0",
                     sample_valid, sample_out, done, underrun, exp_v);
            errors++;
        end
        step();
    endtask

    task automatic test_abort();
        int exp_v;
        for (int i = 0; i < 4; i++) mem[i] = $urandom;
        do_start(4);
        for (int i = 0; i < 2; i++) begin
            wait_n(9);
            do_tick();
            exp_v = expect_sample(mem[i]);
            checks++;
            if (sample_valid !== 1'b1 || int'(sample_out) !== exp_v) begin
                $display("FAIL abort_first[%0d]: valid=%b out=%0d, required 1 %0d", i, sample_valid, sample_out, exp_v);
                errors++;
            end
        end
        wait_n(9);
        mem[0] = $urandom;
        mem[1] = $urandom;
        start = 1'b1;
        window_len = AW'(2);
        sample_tick = 1'b1;
        step();
        start = 1'b0;
        sample_tick = 1'b0;
        checks++;
        if (sample_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1 || underrun !== 1'b0) begin
            $display("FAIL abort_restart: valid=%b done=%b busy=%b underrun=%b, required 0 0 1 0",
                     sample_valid, done, busy, underrun);
            errors++;
        end
        for (int i = 0; i < 2; i++) begin
            wait_n(5);
            do_tick();
            exp_v = expect_sample(mem[i]);
            checks++;
            if (sample_valid !== 1'b1 || int'(sample_out) !== exp_v || done !== ((i == 1) ? 1'b1 : 1'b0)) begin
                $display("FAIL abort_second[%0d]: valid=%b out=%0d done=%b, required 1 %0d %0d",
                         i, sample_valid, sample_out, done, exp_v, (i == 1) ? 1 : 0);
                errors++;
            end
        end
        step();
    endtask

    task automatic test_reset_mid();
        mem[0] = 32'h0000_1400;
        do_start(3);
        wait_n(9);
        do_tick();
        checks++;
        if (int'(sample_out) !== 5) begin
            $display("FAIL midreset_pre: out=%0d, required 5", sample_out);
            errors++;
        end
        step();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        checks++;
        if (sample_out !== 16'sd0 || busy !== 1'b0 || sample_valid !== 1'b0 || done !== 1'b0 ||
            underrun !== 1'b0 || clear_en !== 1'b0 || read_addr !== '0 || clear_addr !== '0) begin
            $display("FAIL midreset_outputs: out=%0d busy=%b valid=%b done=%b underrun=%b clear_en=%b raddr=%0d caddr=%0d",
                     sample_out, busy, sample_valid, done, underrun, clear_en, read_addr, clear_addr);
            errors++;
        end
        wait_n(5);
        do_tick();
        checks++;
        if (sample_valid !== 1'b0 || underrun !== 1'b0) begin
            $display("FAIL midreset_tick: valid=%b underrun=%b, required 0 0", sample_valid, underrun);
            errors++;
        end
        do_start(0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || sample_valid !== 1'b0) begin
            $display("FAIL zero_len: done=%b busy=%b valid=%b, required 1 0 0", done, busy, sample_valid);
            errors++;
        end
        step();
        checks++;
        if (done !== 1'b0 || sample_valid !== 1'b0) begin
            $display("FAIL zero_len_tail: done=%b valid=%b, required 0 0", done, sample_valid);
            errors++;
        end
    endtask

    task automatic test_random();
        int len;
        for (int w = 0; w < 6; w++) begin
            len = int'($urandom_range(8, 1));
            for (int i = 0; i < len; i++) mem[i] = $urandom;
            run_window("random", len, 3, 12);
        end
    endtask

    task automatic test_clamp();
        for (int i = 0; i < WS; i++) mem[i] = $urandom;
        run_window("clamp", 4095, 3, 3);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        test_reset();
        test_basic();
        test_saturation();
        test_underrun();
        test_abort();
        test_reset_mid();
        test_random();
        test_clamp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
